// File: rtl/pipe_skid_reg.sv
// pipe_skid_reg
//   Inter-stage pipeline register with valid/ready back-pressure, a 2-entry
//   skid buffer (main + skid), synchronous flush and per-beat NOP kill.
//   in_ready comes straight from a flop, so a downstream stall never forms a
//   combinational path back to the upstream stage.
//
// Ports
//   clk          rising-edge clock
//   rst          synchronous active-high reset
//   in_valid     upstream beat valid
//   in_ready     stage can accept (registered)
//   in_inst      upstream instruction
//   in_payload   upstream payload
//   in_kill      store the accepted beat with NOP_INST as its instruction
//   flush        discard all held beats
//   out_valid    head beat valid
//   out_ready    downstream accepts head beat
//   out_inst     head instruction, NOP_INST when out_valid=0
//   out_payload  head payload, holds last value when out_valid=0
//   occupancy    number of held beats (0..2)
//
// state | meaning
// EMPTY | no beat held, occupancy 0
// ONE   | main entry valid, occupancy 1
// TWO   | main and skid entries valid, occupancy 2, in_ready low
module pipe_skid_reg #(
    parameter int                INST_W   = 32,
    parameter int                PAY_W    = 128,
    parameter logic [INST_W-1:0] NOP_INST = INST_W'(32'hff000000)
) (
    input  logic              clk,
    input  logic              rst,
    input  logic              in_valid,
    output logic              in_ready,
    input  logic [INST_W-1:0] in_inst,
    input  logic [PAY_W-1:0]  in_payload,
    input  logic              in_kill,
    input  logic              flush,
    output logic              out_valid,
    input  logic              out_ready,
    output logic [INST_W-1:0] out_inst,
    output logic [PAY_W-1:0]  out_payload,
    output logic [1:0]        occupancy
);

    // Encoding equals occupancy so the state flop drives occupancy directly.
    typedef enum logic [1:0] {
        EMPTY = 2'd0,
        ONE   = 2'd1,
        TWO   = 2'd2
    } state_t;

    state_t             state, state_nxt;
    logic               in_ready_q;
    logic [INST_W-1:0]  main_inst, skid_inst;
    logic [PAY_W-1:0]   main_pay, skid_pay;

    logic               accept, drain;
    logic               load_main, load_skid, move_skid;
    logic [INST_W-1:0]  in_inst_eff;

    assign out_valid   = (state != EMPTY);
    assign in_ready    = in_ready_q;
    assign accept      = in_valid & in_ready_q;
    assign drain       = out_valid & out_ready;
    assign in_inst_eff = in_kill ? NOP_INST : in_inst;
    assign out_inst    = out_valid ? main_inst : NOP_INST;
    assign out_payload = main_pay;
    assign occupancy   = state;

    always_comb begin
        state_nxt = state;
        load_main = 1'b0;
        load_skid = 1'b0;
        move_skid = 1'b0;
        if (flush) begin
            // Flush wins over accept and drain; an offered beat is dropped.
            state_nxt = EMPTY;
        end else begin
            case (state)
                EMPTY: begin
                    if (accept) begin
                        load_main = 1'b1;
                        state_nxt = ONE;
                    end
                end
                ONE: begin
                    if (accept && drain) begin
                        load_main = 1'b1;
                    end else if (accept) begin
                        load_skid = 1'b1;
                        state_nxt = TWO;
                    end else if (drain) begin
                        state_nxt = EMPTY;
                    end
                end
                TWO: begin
                    if (drain) begin
                        move_skid = 1'b1;
                        state_nxt = ONE;
                    end
                end
                default: state_nxt = EMPTY;
            endcase
        end
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            state      <= EMPTY;
            in_ready_q <= 1'b1;
            main_inst  <= NOP_INST;
            main_pay   <= '0;
            skid_inst  <= '0;
            skid_pay   <= '0;
        end else begin
            state      <= state_nxt;
            in_ready_q <= (state_nxt != TWO);
            if (load_main) begin
                main_inst <= in_inst_eff;
                main_pay  <= in_payload;
            end
            if (load_skid) begin
                skid_inst <= in_inst_eff;
                skid_pay  <= in_payload;
            end
            if (move_skid) begin
                main_inst <= skid_inst;
                main_pay  <= skid_pay;
                skid_inst <= '0;
                skid_pay  <= '0;
            end
        end
    end

endmodule

// File: tb/tb_pipe_skid_reg.sv
module tb_pipe_skid_reg;

    localparam logic [31:0] NOP = 32'hff000000;

    logic clk = 1'b0;
    always #5 clk = ~clk;

    int checks = 0;
    int errors = 0;

    // Directed instance, default widths
    logic         rst, in_valid, in_ready, in_kill, flush, out_valid, out_ready;
    logic [31:0]  in_inst, out_inst;
    logic [127:0] in_payload, out_payload;
    logic [1:0]   occupancy;

    pipe_skid_reg dut (
        .clk(clk), .rst(rst), .in_valid(in_valid), .in_ready(in_ready),
        .in_inst(in_inst), .in_payload(in_payload), .in_kill(in_kill),
        .flush(flush), .out_valid(out_valid), .out_ready(out_ready),
        .out_inst(out_inst), .out_payload(out_payload), .occupancy(occupancy)
    );

    // Randomised instance, narrow widths
    logic        r_in_valid, r_in_ready, r_in_kill, r_flush, r_out_valid, r_out_ready;
    logic [15:0] r_in_inst, r_out_inst;
    logic [63:0] r_in_payload, r_out_payload;
    logic [1:0]  r_occupancy;

    pipe_skid_reg #(.INST_W(16), .PAY_W(64)) dut_r (
        .clk(clk), .rst(rst), .in_valid(r_in_valid), .in_ready(r_in_ready),
        .in_inst(r_in_inst), .in_payload(r_in_payload), .in_kill(r_in_kill),
        .flush(r_flush), .out_valid(r_out_valid), .out_ready(r_out_ready),
        .out_inst(r_out_inst), .out_payload(r_out_payload), .occupancy(r_occupancy)
    );

    a_ready_only_full: assert property (@(posedge clk) disable iff (rst)
        !r_in_ready |-> (r_occupancy == 2'd2));

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic test_reset();
        rst = 1'b1; in_valid = 0; in_inst = 0; in_payload = 0; in_kill = 0;
        flush = 0; out_ready = 0;
        r_in_valid = 0; r_in_inst = 0; r_in_payload = 0; r_in_kill = 0;
        r_flush = 0; r_out_ready = 0;
        tick(); tick();
        checks++; if (out_valid !== 1'b0) begin errors++; $display("FAIL reset_out_valid got %0b exp 0", out_valid); end
        checks++; if (in_ready !== 1'b1) begin errors++; $display("FAIL reset_in_ready got %0b exp 1", in_ready); end
        checks++; if (out_inst !== NOP) begin errors++; $display("FAIL reset_out_inst got %h exp %h", out_inst, NOP); end
        checks++; if (out_payload !== 128'd0) begin errors++; $display("FAIL reset_out_payload got %h exp 0", out_payload); end
        checks++; if (occupancy !== 2'd0) begin errors++; $display("FAIL reset_occupancy got %0d exp 0", occupancy); end
        rst = 1'b0;
    endtask

    task automatic test_stream();
        out_ready = 1;
        for (int i = 1; i <= 5; i++) begin
            in_valid = 1; in_inst = 32'(i); in_payload = 128'(i * 16);
            tick();
            checks++; if (out_valid !== 1'b1 || out_inst !== 32'(i)) begin errors++; $display("FAIL stream_inst[%0d] got v=%0b %h exp v=1 %h", i, out_valid, out_inst, 32'(i)); end
            checks++; if (out_payload !== 128'(i * 16)) begin errors++; $display("FAIL stream_payload[%0d] got %h exp %h", i, out_payload, 128'(i * 16)); end
            checks++; if (occupancy !== 2'd1 || in_ready !== 1'b1) begin errors++; $display("FAIL stream_occ[%0d] got occ=%0d rdy=%0b exp occ=1 rdy=1", i, occupancy, in_ready); end
        end
        in_valid = 0;
        tick();
        checks++; if (out_valid !== 1'b0 || out_inst !== NOP || occupancy !== 2'd0) begin errors++; $display("FAIL stream_drain got v=%0b %h occ=%0d exp v=0 %h occ=0", out_valid, out_inst, occupancy, NOP); end
    endtask

    task automatic test_stall_skid();
        out_ready = 1; in_valid = 1; in_inst = 32'h10; in_payload = 128'h10;
        tick();
        out_ready = 0; in_inst = 32'h11; in_payload = 128'h11;
        tick();
        checks++; if (occupancy !== 2'd2 || in_ready !== 1'b0) begin errors++; $display("FAIL stall_full got occ=%0d rdy=%0b exp occ=2 rdy=0", occupancy, in_ready); end
        in_inst = 32'h12; in_payload = 128'h12;
        tick(); tick();
        checks++; if (out_inst !== 32'h10 || occupancy !== 2'd2) begin errors++; $display("FAIL stall_hold got %h occ=%0d exp 00000010 occ=2", out_inst, occupancy); end
        out_ready = 1;
        tick();
        checks++; if (out_inst !== 32'h11 || out_payload !== 128'h11 || occupancy !== 2'd1) begin errors++; $display("FAIL resume_skid got %h occ=%0d exp 00000011 occ=1", out_inst, occupancy); end
        checks++; if (in_ready !== 1'b1) begin errors++; $display("FAIL resume_ready got %0b exp 1", in_ready); end
        tick();
        checks++; if (out_inst !== 32'h12 || out_valid !== 1'b1) begin errors++; $display("FAIL resume_next got v=%0b %h exp v=1 00000012", out_valid, out_inst); end
        in_valid = 0;
        tick();
        checks++; if (occupancy !== 2'd0) begin errors++; $display("FAIL resume_empty got occ=%0d exp 0", occupancy); end
    endtask

    task automatic test_flush();
        out_ready = 0; in_valid = 1; in_inst = 32'hA; in_payload = 128'hA0;
        tick();
        in_inst = 32'hB; in_payload = 128'hB0;
        tick();
        checks++; if (occupancy !== 2'd2) begin errors++; $display("FAIL flush_pre got occ=%0d exp 2", occupancy); end
        flush = 1; in_inst = 32'hC; in_payload = 128'hC0;
        tick();
        flush = 0; in_valid = 0;
        checks++; if (out_valid !== 1'b0 || out_inst !== NOP || occupancy !== 2'd0 || in_ready !== 1'b1) begin errors++; $display("FAIL flush_two got v=%0b %h occ=%0d rdy=%0b exp v=0 %h occ=0 rdy=1", out_valid, out_inst, occupancy, in_ready, NOP); end
        checks++; if (out_payload !== 128'hA0) begin errors++; $display("FAIL flush_payload got %h exp a0", out_payload); end
        // Flush in ONE with a beat offered while in_ready=1: beat is dropped.
        in_valid = 1; in_inst = 32'hD; in_payload = 128'hD0;
        tick();
        flush = 1; in_inst = 32'hE; in_payload = 128'hE0;
        tick();
        flush = 0; in_valid = 0; out_ready = 1;
        checks++; if (out_valid !== 1'b0 || occupancy !== 2'd0 || out_payload !== 128'hD0) begin errors++; $display("FAIL flush_one got v=%0b occ=%0d pay=%h exp v=0 occ=0 pay=d0", out_valid, occupancy, out_payload); end
        tick(); tick();
        checks++; if (out_valid !== 1'b0 || out_inst !== NOP) begin errors++; $display("FAIL flush_nothing_left got v=%0b %h exp v=0 %h", out_valid, out_inst, NOP); end
    endtask

    task automatic test_kill();
        out_ready = 0; in_valid = 1; in_inst = 32'h12345678; in_payload = 128'hBEEF; in_kill = 1;
        tick();
        in_valid = 0; in_kill = 0;
        checks++; if (out_valid !== 1'b1 || out_inst !== NOP || out_payload !== 128'hBEEF) begin errors++; $display("FAIL kill_beat got v=%0b %h pay=%h exp v=1 %h pay=beef", out_valid, out_inst, out_payload, NOP); end
        checks++; if (occupancy !== 2'd1) begin errors++; $display("FAIL kill_occ got %0d exp 1", occupancy); end
        // in_kill without accept must not disturb the next normal beat.
        in_kill = 1;
        tick();
        in_kill = 0; out_ready = 1;
        tick();
        checks++; if (out_valid !== 1'b0 || occupancy !== 2'd0) begin errors++; $display("FAIL kill_drain got v=%0b occ=%0d exp v=0 occ=0", out_valid, occupancy); end
    endtask

    task automatic test_reset_mid();
        out_ready = 0; in_valid = 1; in_inst = 32'h5; in_payload = 128'h55;
        tick();
        in_inst = 32'h6; in_payload = 128'h66;
        tick();
        in_valid = 0; rst = 1;
        tick();
        rst = 0;
        checks++; if (out_valid !== 1'b0 || in_ready !== 1'b1 || out_inst !== NOP || occupancy !== 2'd0) begin errors++; $display("FAIL rstmid_ctrl got v=%0b rdy=%0b %h occ=%0d exp v=0 rdy=1 %h occ=0", out_valid, in_ready, out_inst, occupancy, NOP); end
        checks++; if (out_payload !== 128'd0) begin errors++; $display("FAIL rstmid_payload got %h exp 0", out_payload); end
        in_valid = 1; in_inst = 32'h7; in_payload = 128'h77;
        tick();
        in_valid = 0;
        checks++; if (out_valid !== 1'b1 || out_inst !== 32'h7) begin errors++; $display("FAIL rstmid_after got v=%0b %h exp v=1 00000007", out_valid, out_inst); end
        out_ready = 1;
        tick();
    endtask

    task automatic test_random_backpressure();
        logic [15:0] q_inst[$];
        logic [63:0] q_pay[$];
        int sent = 0, rcvd = 0, cyc = 0;
        logic [15:0] e_inst;
        logic [63:0] e_pay;
        while (rcvd < 1000 && cyc < 20000) begin
            r_in_valid  = (sent < 1000) && ($urandom_range(0, 3) != 0);
            r_out_ready = ($urandom_range(0, 2) != 0);
            r_in_inst   = 16'($urandom);
            r_in_payload = {$urandom, $urandom};
            #1;
            if (r_out_valid && r_out_ready) begin
                if (q_inst.size() == 0) begin
                    checks++; errors++;
                    $display("FAIL rand_spurious beat %h with empty scoreboard", r_out_inst);
                end else begin
                    e_inst = q_inst.pop_front();
                    e_pay  = q_pay.pop_front();
                    checks++;
                    if (r_out_inst !== e_inst || r_out_payload !== e_pay) begin
                        errors++;
                        $display("FAIL rand_beat[%0d] got %h/%h exp %h/%h", rcvd, r_out_inst, r_out_payload, e_inst, e_pay);
                    end
                end
                rcvd++;
            end
            if (r_in_valid && r_in_ready) begin
                q_inst.push_back(r_in_inst);
                q_pay.push_back(r_in_payload);
                sent++;
            end
            if (!r_in_ready && r_occupancy != 2'd2) begin
                checks++; errors++;
                $display("FAIL rand_ready got rdy=0 occ=%0d exp occ=2", r_occupancy);
            end
            tick();
            cyc++;
        end
        r_in_valid = 0; r_out_ready = 0;
        checks++; if (rcvd != 1000 || q_inst.size() != 0) begin errors++; $display("FAIL rand_count got rcvd=%0d left=%0d exp rcvd=1000 left=0 (cycles %0d)", rcvd, q_inst.size(), cyc); end
    endtask

    initial begin
        test_reset();
        test_stream();
        test_stall_skid();
        test_flush();
        test_kill();
        test_reset_mid();
        test_random_backpressure();
        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

endmodule

// File: doc/pipe_skid_reg.md
Name: pipe_skid_reg

Overview:
- Parametrised inter-stage pipeline register carrying one instruction word plus a flat payload bus between adjacent stages (IF/ID, ID/EX, EX/MEM, MEM/WB).
- Adds what the fixed-width stage registers lack:
  - valid/ready back-pressure with a 2-entry skid buffer, so a stall never needs a combinational ready path;
  - synchronous flush;
  - per-beat NOP kill;
  - synchronous reset.

Parameters:
- INST_W, 32, instruction field width.
- PAY_W, 128, payload width: concatenated PC+4, operands, immediates, control bits, packed by the instantiating stage.
- NOP_INST, 32'hff000000, instruction value presented whenever the stage holds no valid beat or a beat is killed; width INST_W.

Ports:
- clk  in  1  rising-edge clock.
- rst  in  1  synchronous, active-high reset.
- in_valid  in  1  upstream beat valid.
- in_ready  out  1  stage can accept; driven directly from a flop.
- in_inst  in  INST_W  upstream instruction.
- in_payload  in  PAY_W  upstream payload.
- in_kill  in  1  the accepted beat is stored with NOP_INST in place of in_inst.
- flush  in  1  discard all held beats.
- out_valid  out  1  head beat valid.
- out_ready  in  1  downstream accepts head beat.
- out_inst  out  INST_W  head instruction; NOP_INST when out_valid=0.
- out_payload  out  PAY_W  head payload; holds its last value when out_valid=0.
- occupancy  out  2  number of held beats, 0..2.

Behaviour:
- Storage:
  - Main entry drives the out_* ports.
  - Skid entry holds the beat accepted while the main entry is stalled.
- States:
  - EMPTY (occ 0), ONE (occ 1, main valid), TWO (occ 2, both valid).
  - The state encodes occupancy directly.
- Handshakes: accept = in_valid & in_ready; drain = out_valid & out_ready.
- in_ready is registered: 1 in EMPTY/ONE, 0 in TWO. It is computed from next state and never depends combinationally on out_ready.
- Transitions when flush=0:
  - EMPTY: accept -> ONE (beat into main).
  - ONE:
    - accept & drain -> ONE (new beat into main).
    - accept & !drain -> TWO (new beat into skid).
    - !accept & drain -> EMPTY.
    - otherwise hold.
  - TWO (no accept possible): drain -> ONE (skid moves to main, skid cleared); otherwise hold.
- Ordering: beats leave in acceptance order; the skid entry is never presented ahead of main.
- Kill: a beat accepted with in_kill=1 is stored with inst=NOP_INST and the payload as presented. It stays valid and still consumes a slot and a handshake. in_kill is ignored without accept.
- Flush:
  - Next state EMPTY; out_valid=0, out_inst=NOP_INST, in_ready=1.
  - Takes priority over accept and drain in the same cycle. A beat offered that cycle is dropped, although in_ready was 1 when it was offered. Upstream is responsible for squashing it.
  - out_payload is not cleared.
- Reset (synchronous, highest priority, also mid-transfer): state EMPTY, out_valid=0, in_ready=1, out_inst=NOP_INST, out_payload=0, skid contents=0, occupancy=0.
- Latency: 1 cycle from accept to out_valid when empty. Throughput: 1 beat/cycle with out_ready held high.
- No arithmetic on data: widths pass through unmodified.
- occupancy is a flop-driven copy of the state.

Test Plan:
- Reset then stream: rst 2 cycles, then in_valid=1 with in_inst=0x00000001..0x00000005, out_ready=1 -> out_inst 0x1..0x5 on consecutive cycles, each one cycle after accept; in_ready stays 1; occupancy=1 throughout.
- Stall and skid:
  - Stall: while streaming, drop out_ready for 3 cycles -> occupancy goes 1->2; in_ready falls the cycle after the skid fills; out_inst holds its value.
  - Resume: raise out_ready -> skid beat follows the main beat in order with no loss or duplication; in_ready returns high one cycle later.
- Flush in TWO: hold 0xA (main) and 0xB (skid), assert flush with in_valid=1 carrying 0xC -> next cycle out_valid=0, out_inst=0xff000000, occupancy=0, in_ready=1; 0xC never appears at the output.
- Kill: accept in_inst=0x12345678 with payload 0xBEEF and in_kill=1 -> out_valid=1, out_inst=0xff000000, out_payload=0xBEEF; consumes one downstream handshake.
- Reset mid-operation: in TWO with out_ready=0, assert rst one cycle -> all outputs at reset values next cycle, including out_payload=0; a subsequent beat 0x7 appears one cycle after accept.
- Randomised back-pressure: 1000 beats with random in_valid/out_ready and PAY_W=64, INST_W=16 override -> scoreboard shows in-order, lossless delivery; a concurrent assertion checks in_ready=0 only when occupancy=2.
